// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared types and constants for the mux scan sequencer
package mux_scan_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, PRESENT} scan_state_t;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;
endpackage

// File: rtl/dwell_counter.sv
// dwell_counter: latches the dwell period (0 treated as 1) and flags the last cycle of each dwell
module dwell_counter #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               en,
  input  logic [DWELL_W-1:0] dwell_in,
  output logic               tc
);
  logic [DWELL_W-1:0] dwell_q, dwell_d, cnt_q, cnt_d;
  assign tc = cnt_q == dwell_q - DWELL_W'(1);
  // load restarts the count; otherwise count up and fold back to 0 at terminal count
  always_comb begin
    dwell_d = load ? ((dwell_in == '0) ? DWELL_W'(1) : dwell_in) : dwell_q;
    cnt_d   = load ? '0 : en ? (tc ? '0 : cnt_q + DWELL_W'(1)) : cnt_q;
  end
  // dwell and count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_q <= DWELL_W'(1);
      cnt_q   <= '0;
    end else begin
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: steps a 4:1 mux through its channels and presents the sampled word; MUX_SCAN_CONT_EN enables continuous rescans
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               mux_out,
  output logic               s1,
  output logic               s2,
  output logic [3:0]         word_out,
  output logic               word_valid,
  input  logic               word_ready,
  output logic               busy
);
  scan_state_t state_q, state_d;
  logic [SEL_W-1:0]  ch_q, ch_d;
  logic [NUM_CH-1:0] acc_q, acc_d, word_q, word_d;
  logic tc, hs, cont, load, last, sample;
  assign hs     = (state_q == PRESENT) && word_ready;
`ifdef MUX_SCAN_CONT_EN
  assign cont   = hs && start;
`else
  assign cont   = 1'b0;
`endif
  assign load   = ((state_q == IDLE) && start) || cont;
  assign last   = ch_q == SEL_W'(NUM_CH - 1);
  assign sample = (state_q == SETTLE) && tc;
  dwell_counter #(.DWELL_W(DWELL_W)) u_dwell (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .en       (state_q == SETTLE),
    .dwell_in (dwell),
    .tc       (tc)
  );
  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end
  // next state: scan on start, present after the last channel, leave on handshake
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? SETTLE : IDLE;
      SETTLE:  state_d = (tc && last) ? PRESENT : SETTLE;
      PRESENT: state_d = cont ? SETTLE : hs ? IDLE : PRESENT;
      default: state_d = IDLE;
    endcase
  end
  // outputs: selects only driven while settling
  always_comb begin
    {s2, s1}   = (state_q == SETTLE) ? ch_q : '0;
    word_valid = state_q == PRESENT;
    busy       = state_q != IDLE;
    word_out   = word_q;
  end
  // channel advance, per-channel sample capture, and word update on the final sample
  always_comb begin
    ch_d  = load ? '0 : (sample && !last) ? ch_q + SEL_W'(1) : ch_q;
    acc_d = load ? '0 : acc_q;
    if (sample) acc_d[ch_q] = mux_out;
    word_d = (sample && last) ? acc_d : word_q;
  end
  // datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q   <= '0;
      acc_q  <= '0;
      word_q <= '0;
    end else begin
      ch_q   <= ch_d;
      acc_q  <= acc_d;
      word_q <= word_d;
    end
  end
endmodule
